seq_gen_arbiter: RTL and testbench
==================================

Name: seq_gen_arbiter

Overview:
- Round-robin controller that shares one sequence_gen datapath among NUM_REQ requesters.
- Latches the winning request's mode, order and seed, then drives the 2-cycle load and waits for done.
- Returns the result to the winner, then issues clear.
- Sits between the requester agents and the sequence_gen instance in top_hdl.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort (used only with the optional feature)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  reset, asynchronous, active-high
req  input  NUM_REQ  per-requester request level; held until grant
req_fib  input  NUM_REQ  per-requester mode: 1=fibonacci, 0=triangle
req_order  input  16*NUM_REQ  per-requester order, slice i = [16i+15:16i]
req_data  input  64*NUM_REQ  per-requester seed, slice i = [64i+63:64i]
grant  output  NUM_REQ  one-hot 1-cycle pulse; request captured
rsp_valid  output  NUM_REQ  one-hot 1-cycle pulse; rsp_* valid for that requester
rsp_data  output  64  result value
rsp_overflow  output  1  result overflowed
rsp_error  output  1  datapath error, order==0, or timeout
busy  output  1  high in any state except IDLE
gen_reset_n  output  1  active-low reset to sequence_gen
gen_fibonacci  output  1  mode to sequence_gen
gen_triangle  output  1  mode to sequence_gen
gen_load  output  1  load strobe, 2 cycles
gen_clear  output  1  clear strobe, 1 cycle
gen_order  output  16  latched order
gen_data_in  output  64  latched seed
gen_done  input  1  result ready, 1-cycle pulse
gen_data_out  input  64  result
gen_overflow  input  1  overflow flag
gen_error  input  1  error flag

Behaviour:
- Reset (async, immediate): state IDLE, RR pointer=0.
  - All outputs 0 except gen_reset_n=0 while reset is high, 1 after.
  - Latched order/seed registers cleared. Reset mid-operation abandons the transaction silently (no rsp_valid).
- States: IDLE, LOAD1, LOAD2, WAIT, RESP, CLEAR (plus ABORT with the optional feature).
- IDLE:
  - If any req is set, the winner is the first set bit scanning from pointer upward, with wrap.
  - Latch req_fib/order/data of the winner. Pointer <= winner+1 mod NUM_REQ.
  - If the latched order==0: next state RESP with error=1, data=0. Otherwise next state LOAD1.
  - No req: stay IDLE.
- grant[winner] pulses in the first cycle after selection (LOAD1, or RESP for order==0).
- LOAD1, LOAD2: gen_load=1. Then go to WAIT.
- gen_fibonacci/gen_triangle: driven from the latched mode during LOAD1, LOAD2 and WAIT only; 0 elsewhere. Never both 1.
- gen_order/gen_data_in: hold latched values from LOAD1 through CLEAR.
- gen_error=1 in LOAD1, LOAD2 or WAIT: capture error=1, data=0, overflow=0; go to RESP. Skips any remaining load cycle.
- WAIT:
  - On gen_done=1: capture gen_data_out, gen_overflow, gen_error; go to RESP.
  - gen_done together with gen_error: error=1, data captured as is.
  - gen_done outside WAIT is ignored.
- RESP: rsp_valid[winner]=1 for one cycle. rsp_data/overflow/error hold the captured values and stay stable until the next RESP. Then go to CLEAR, or to IDLE if order==0.
- CLEAR: gen_clear=1 for one cycle. Then IDLE.
- Latency: selection cycle T; grant T+1; load T+1..T+2; WAIT from T+3; rsp_valid 1 cycle after gen_done; gen_clear the cycle after that; IDLE-ready the next cycle.
- Min back-to-back spacing: T to next selection = 6 cycles when done arrives in the first WAIT cycle.
- req changes after grant are ignored. A requester that keeps req high is re-arbitrated normally; RR prevents starvation.

Optional Feature:
- SEQ_GEN_ARBITER_TIMEOUT_EN defined:
  - A 16-bit counter clears on WAIT entry and increments each WAIT cycle.
  - At TIMEOUT_CYCLES without gen_done: enter ABORT, drive gen_reset_n=0 for 2 cycles.
  - Then RESP with error=1, data=0, overflow=0. Then IDLE; CLEAR is skipped.
- Not defined: no counter, no ABORT state; WAIT persists until gen_done or reset.

Test Plan:
- Single requester: req[0], fib=1, order=10, seed=1; bench stub returns done 5 cycles after WAIT entry with data_out=55.
  - Expect: grant[0] at T+1; gen_load high T+1..T+2; rsp_valid[0] with rsp_data=55, error=0; gen_clear the next cycle.
- All 4 req held high, stub done immediately:
  - Expect grant order 0,1,2,3,0. gen_triangle/gen_fibonacci match each requester's req_fib.
- req[2] with order=0:
  - Expect grant[2] and rsp_valid[2] in the same cycle, rsp_error=1, rsp_data=0, gen_load never asserted.
- Stub asserts gen_error in LOAD2 (order=5):
  - Expect no third load cycle, rsp_error=1, gen_clear follows.
- Reset asserted mid-WAIT:
  - Expect outputs 0 and gen_reset_n=0 immediately, no rsp_valid. After release, req[1] is granted first if pointer=0 and req[0] is low.
- With SEQ_GEN_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no gen_done:
  - Expect gen_reset_n low 2 cycles after 8 WAIT cycles, rsp_error=1.
  - Without the macro: still in WAIT and busy=1 after 100 cycles.

Source files
------------

// File: rtl/seq_gen_arbiter.sv
// Round-robin front end sharing one sequence_gen datapath among NUM_REQ requesters.
// Define SEQ_GEN_ARBITER_TIMEOUT_EN to add the WAIT timeout and ABORT (datapath reset) path.
module seq_gen_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_fib,
  input  logic [16*NUM_REQ-1:0] req_order,
  input  logic [64*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [63:0]           rsp_data,
  output logic                  rsp_overflow,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  gen_reset_n,
  output logic                  gen_fibonacci,
  output logic                  gen_triangle,
  output logic                  gen_load,
  output logic                  gen_clear,
  output logic [15:0]           gen_order,
  output logic [63:0]           gen_data_in,
  input  logic                  gen_done,
  input  logic [63:0]           gen_data_out,
  input  logic                  gen_overflow,
  input  logic                  gen_error
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("seq_gen_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD1, S_LOAD2, S_WAIT, S_RESP, S_CLEAR
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
    , S_ABORT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic               fib_q, fib_d;
  logic [15:0]        order_q, order_d;
  logic [63:0]        seed_q, seed_d;
  logic               zero_q, zero_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               rovf_q, rovf_d;
  logic               rerr_q, rerr_d;
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
  logic [15:0]        cnt_q, cnt_d;
  logic               abt_q, abt_d;
`endif

  logic               found;
  logic [PTR_W-1:0]   win, cand, ptr_nxt;
  logic [15:0]        sel_order;
  logic [NUM_REQ-1:0] onehot;
  logic               skip_clear;

  // Round-robin scan starting at the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    sel_order = req_order[16*win +: 16];
    ptr_nxt   = (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
  end

`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
  assign skip_clear = zero_q | abt_q;
`else
  assign skip_clear = zero_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      fib_q   <= 1'b0;
      order_q <= '0;
      seed_q  <= '0;
      zero_q  <= 1'b0;
      rdata_q <= '0;
      rovf_q  <= 1'b0;
      rerr_q  <= 1'b0;
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      abt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      fib_q   <= fib_d;
      order_q <= order_d;
      seed_q  <= seed_d;
      zero_q  <= zero_d;
      rdata_q <= rdata_d;
      rovf_q  <= rovf_d;
      rerr_q  <= rerr_d;
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abt_q   <= abt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    fib_d   = fib_q;
    order_d = order_q;
    seed_d  = seed_q;
    zero_d  = zero_q;
    rdata_d = rdata_q;
    rovf_d  = rovf_q;
    rerr_d  = rerr_q;
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    abt_d   = abt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = win;
          ptr_d   = ptr_nxt;
          fib_d   = req_fib[win];
          order_d = sel_order;
          seed_d  = req_data[64*win +: 64];
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
          abt_d   = 1'b0;
`endif
          // Zero order never touches the datapath: answer with an error directly.
          if (sel_order == 16'd0) begin
            zero_d  = 1'b1;
            rdata_d = '0;
            rovf_d  = 1'b0;
            rerr_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            zero_d  = 1'b0;
            state_d = S_LOAD1;
          end
        end
      end
      S_LOAD1, S_LOAD2: begin
        if (gen_error) begin
          rdata_d = '0;
          rovf_d  = 1'b0;
          rerr_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = (state_q == S_LOAD1) ? S_LOAD2 : S_WAIT;
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (gen_done) begin
          rdata_d = gen_data_out;
          rovf_d  = gen_overflow;
          rerr_d  = gen_error;
          state_d = S_RESP;
        end else if (gen_error) begin
          rdata_d = '0;
          rovf_d  = 1'b0;
          rerr_d  = 1'b1;
          state_d = S_RESP;
        end
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          cnt_d   = '0;
          abt_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
      S_ABORT: begin
        if (cnt_q == 16'd1) begin
          rdata_d = '0;
          rovf_d  = 1'b0;
          rerr_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      S_RESP:  state_d = skip_clear ? S_IDLE : S_CLEAR;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    onehot        = '0;
    onehot[win_q] = 1'b1;
    grant         = '0;
    rsp_valid     = '0;
    busy          = (state_q != S_IDLE);
    gen_reset_n   = ~reset;
    gen_load      = 1'b0;
    gen_clear     = 1'b0;
    gen_fibonacci = 1'b0;
    gen_triangle  = 1'b0;
    case (state_q)
      S_LOAD1: begin
        grant         = onehot;
        gen_load      = 1'b1;
        gen_fibonacci = fib_q;
        gen_triangle  = ~fib_q;
      end
      S_LOAD2: begin
        gen_load      = 1'b1;
        gen_fibonacci = fib_q;
        gen_triangle  = ~fib_q;
      end
      S_WAIT: begin
        gen_fibonacci = fib_q;
        gen_triangle  = ~fib_q;
      end
      S_RESP: begin
        rsp_valid = onehot;
        if (zero_q) grant = onehot;
      end
      S_CLEAR: gen_clear = 1'b1;
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
      S_ABORT: gen_reset_n = 1'b0;
`endif
      default: ;
    endcase
  end

  assign rsp_data     = rdata_q;
  assign rsp_overflow = rovf_q;
  assign rsp_error    = rerr_q;
  assign gen_order    = order_q;
  assign gen_data_in  = seed_q;

endmodule

// File: tb/tb_seq_gen_arbiter.sv
// Directed bench for seq_gen_arbiter; the bench itself plays the sequence_gen stub.
module tb_seq_gen_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req, req_fib;
  logic [16*N-1:0] req_order;
  logic [64*N-1:0] req_data;
  logic [N-1:0]    grant, rsp_valid;
  logic [63:0]     rsp_data;
  logic            rsp_overflow, rsp_error, busy;
  logic            gen_reset_n, gen_fibonacci, gen_triangle, gen_load, gen_clear;
  logic [15:0]     gen_order;
  logic [63:0]     gen_data_in;
  logic            gen_done;
  logic [63:0]     gen_data_out;
  logic            gen_overflow, gen_error;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_g;

  seq_gen_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_fib(req_fib), .req_order(req_order),
    .req_data(req_data), .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .busy(busy),
    .gen_reset_n(gen_reset_n), .gen_fibonacci(gen_fibonacci), .gen_triangle(gen_triangle),
    .gen_load(gen_load), .gen_clear(gen_clear), .gen_order(gen_order),
    .gen_data_in(gen_data_in), .gen_done(gen_done), .gen_data_out(gen_data_out),
    .gen_overflow(gen_overflow), .gen_error(gen_error)
  );

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = '0; req_fib = '0; req_order = '0; req_data = '0;
    gen_done = 1'b0; gen_data_out = '0; gen_overflow = 1'b0; gen_error = 1'b0;
    #1;
    chk("rst_busy", busy === 1'b0, busy, 1'b0);
    chk("rst_gen_reset_n", gen_reset_n === 1'b0, gen_reset_n, 1'b0);
    chk("rst_grant", grant === 4'b0, grant, 4'b0);
    chk("rst_rsp_data", rsp_data === 64'd0, rsp_data, 64'd0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("rel_gen_reset_n", gen_reset_n === 1'b1, gen_reset_n, 1'b1);

    // Single requester, fibonacci, done a few cycles into WAIT.
    req_fib[0] = 1'b1; req_order[15:0] = 16'd10; req_data[63:0] = 64'd1; req[0] = 1'b1;
    step();
    chk("t1_grant", grant === 4'b0001, grant, 4'b0001);
    chk("t1_load1", gen_load === 1'b1, gen_load, 1'b1);
    chk("t1_fib", gen_fibonacci === 1'b1, gen_fibonacci, 1'b1);
    chk("t1_tri", gen_triangle === 1'b0, gen_triangle, 1'b0);
    chk("t1_order", gen_order === 16'd10, gen_order, 16'd10);
    chk("t1_seed", gen_data_in === 64'd1, gen_data_in, 64'd1);
    req = '0;
    step();
    chk("t1_load2", gen_load === 1'b1, gen_load, 1'b1);
    chk("t1_grant_off", grant === 4'b0, grant, 4'b0);
    step();
    chk("t1_wait_load", gen_load === 1'b0, gen_load, 1'b0);
    chk("t1_wait_fib", gen_fibonacci === 1'b1, gen_fibonacci, 1'b1);
    repeat (4) step();
    chk("t1_wait_busy", busy === 1'b1, busy, 1'b1);
    chk("t1_wait_rsp", rsp_valid === 4'b0, rsp_valid, 4'b0);
    gen_done = 1'b1; gen_data_out = 64'd55;
    step();
    gen_done = 1'b0;
    chk("t1_rsp_valid", rsp_valid === 4'b0001, rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data === 64'd55, rsp_data, 64'd55);
    chk("t1_rsp_err", rsp_error === 1'b0, rsp_error, 1'b0);
    chk("t1_rsp_fib", gen_fibonacci === 1'b0, gen_fibonacci, 1'b0);
    step();
    chk("t1_clear", gen_clear === 1'b1, gen_clear, 1'b1);
    chk("t1_clear_rsp", rsp_valid === 4'b0, rsp_valid, 4'b0);
    chk("t1_data_hold", rsp_data === 64'd55, rsp_data, 64'd55);
    step();
    chk("t1_idle", busy === 1'b0, busy, 1'b0);
    chk("t1_clear_off", gen_clear === 1'b0, gen_clear, 1'b0);

    // Pointer back to 0, then all four requesting with done in the first WAIT cycle.
    reset = 1'b1; step(); reset = 1'b0;
    req_fib = 4'b0101;
    req_order = {16'd6, 16'd5, 16'd4, 16'd3};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      step();
      chk("rr_grant", grant === exp_g, grant, exp_g);
      chk("rr_fib", gen_fibonacci === req_fib[i % 4], gen_fibonacci, req_fib[i % 4]);
      chk("rr_tri", gen_triangle === ~req_fib[i % 4], gen_triangle, ~req_fib[i % 4]);
      chk("rr_order", gen_order === 16'(3 + (i % 4)), gen_order, 16'(3 + (i % 4)));
      step(); step();
      gen_done = 1'b1; gen_data_out = 64'(100 + i); gen_overflow = (i == 2);
      step();
      gen_done = 1'b0; gen_overflow = 1'b0;
      chk("rr_rsp_valid", rsp_valid === exp_g, rsp_valid, exp_g);
      chk("rr_rsp_data", rsp_data === 64'(100 + i), rsp_data, 64'(100 + i));
      chk("rr_rsp_ovf", rsp_overflow === (i == 2), rsp_overflow, (i == 2));
      step(); step();
      chk("rr_idle", busy === 1'b0, busy, 1'b0);
    end
    req = '0;

    // Zero order: grant and response together, no load.
    req_order[47:32] = 16'd0; req = 4'b0100;
    step();
    chk("z_grant", grant === 4'b0100, grant, 4'b0100);
    chk("z_rsp_valid", rsp_valid === 4'b0100, rsp_valid, 4'b0100);
    chk("z_rsp_err", rsp_error === 1'b1, rsp_error, 1'b1);
    chk("z_rsp_data", rsp_data === 64'd0, rsp_data, 64'd0);
    chk("z_load", gen_load === 1'b0, gen_load, 1'b0);
    req = '0;
    step();
    chk("z_idle", busy === 1'b0, busy, 1'b0);
    chk("z_no_clear", gen_clear === 1'b0, gen_clear, 1'b0);
    chk("z_err_hold", rsp_error === 1'b1, rsp_error, 1'b1);

    // Datapath error during LOAD2.
    req_order[63:48] = 16'd5; req = 4'b1000;
    step();
    chk("e_grant", grant === 4'b1000, grant, 4'b1000);
    req = '0;
    step();
    chk("e_load2", gen_load === 1'b1, gen_load, 1'b1);
    gen_error = 1'b1; gen_data_out = 64'd77;
    step();
    gen_error = 1'b0;
    chk("e_no_load3", gen_load === 1'b0, gen_load, 1'b0);
    chk("e_rsp_valid", rsp_valid === 4'b1000, rsp_valid, 4'b1000);
    chk("e_rsp_err", rsp_error === 1'b1, rsp_error, 1'b1);
    chk("e_rsp_data", rsp_data === 64'd0, rsp_data, 64'd0);
    step();
    chk("e_clear", gen_clear === 1'b1, gen_clear, 1'b1);
    step();

    // Reset in the middle of WAIT.
    req_order[47:32] = 16'd7; req = 4'b0100;
    step();
    chk("r_grant", grant === 4'b0100, grant, 4'b0100);
    req = '0;
    step(); step();
    chk("r_wait_order", gen_order === 16'd7, gen_order, 16'd7);
    reset = 1'b1;
    #1;
    chk("r_busy", busy === 1'b0, busy, 1'b0);
    chk("r_gen_reset_n", gen_reset_n === 1'b0, gen_reset_n, 1'b0);
    chk("r_order", gen_order === 16'd0, gen_order, 16'd0);
    chk("r_seed", gen_data_in === 64'd0, gen_data_in, 64'd0);
    chk("r_fib", (gen_fibonacci | gen_triangle) === 1'b0, gen_fibonacci | gen_triangle, 1'b0);
    chk("r_err", rsp_error === 1'b0, rsp_error, 1'b0);
    step();
    chk("r_rsp_valid", rsp_valid === 4'b0, rsp_valid, 4'b0);
    reset = 1'b0; req = 4'b1010;
    step();
    chk("r_grant_after", grant === 4'b0010, grant, 4'b0010);
    req = '0;
    step(); step();
`ifdef SEQ_GEN_ARBITER_TIMEOUT_EN
    repeat (7) step();
    chk("to_still_wait", gen_reset_n === 1'b1, gen_reset_n, 1'b1);
    chk("to_busy", busy === 1'b1, busy, 1'b1);
    step();
    chk("to_abort1", gen_reset_n === 1'b0, gen_reset_n, 1'b0);
    step();
    chk("to_abort2", gen_reset_n === 1'b0, gen_reset_n, 1'b0);
    step();
    chk("to_rsp_valid", rsp_valid === 4'b0010, rsp_valid, 4'b0010);
    chk("to_rsp_err", rsp_error === 1'b1, rsp_error, 1'b1);
    chk("to_rsp_data", rsp_data === 64'd0, rsp_data, 64'd0);
    chk("to_reset_n_back", gen_reset_n === 1'b1, gen_reset_n, 1'b1);
    step();
    chk("to_idle", busy === 1'b0, busy, 1'b0);
    chk("to_no_clear", gen_clear === 1'b0, gen_clear, 1'b0);
`else
    repeat (100) step();
    chk("w_busy", busy === 1'b1, busy, 1'b1);
    chk("w_rsp", rsp_valid === 4'b0, rsp_valid, 4'b0);
    chk("w_tri", gen_triangle === 1'b1, gen_triangle, 1'b1);
    gen_done = 1'b1; gen_error = 1'b1; gen_data_out = 64'd123;
    step();
    gen_done = 1'b0; gen_error = 1'b0;
    chk("w_rsp_valid", rsp_valid === 4'b0010, rsp_valid, 4'b0010);
    chk("w_rsp_data", rsp_data === 64'd123, rsp_data, 64'd123);
    chk("w_rsp_err", rsp_error === 1'b1, rsp_error, 1'b1);
    step();
    chk("w_clear", gen_clear === 1'b1, gen_clear, 1'b1);
    step();
    chk("w_idle", busy === 1'b0, busy, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
